// File: rtl/memory_data_buffer.sv
// Load-data formatting FIFO: extracts and extends a byte/half/word/full field at push time
// and presents the already-formatted head entry from a register.
module memory_data_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic [1:0]                      in_size,
  input  logic                            in_signed,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] in_offset,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0]      count
);

  localparam int OFF_W = $clog2(DATA_WIDTH/8);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t              memQ [DEPTH];
  logic [PTR_W-1:0]   wrPtrQ, wrPtrD;
  logic [PTR_W-1:0]   rdPtrQ, rdPtrD;
  logic [CNT_W-1:0]   countQ, countD;
  word_t              headQ, headD;

  logic [OFF_W-1:0]   offHalf, offWord;
  logic [BIT_W-1:0]   bitByte, bitHalf, bitWord;
  logic [7:0]         fieldByte;
  logic [15:0]        fieldHalf;
  logic [31:0]        fieldWord;
  word_t              fmtData;
  logic               doPush, doPop;

  assign in_ready  = (countQ != CNT_W'(DEPTH));
  assign out_valid = (countQ != '0);
  assign out_data  = headQ;
  assign count     = countQ;

  assign doPush = in_valid && in_ready && !flush;
  assign doPop  = out_valid && out_ready && !flush;

  // Half and word fields are naturally aligned, so low offset bits are dropped.
  always_comb begin
    offHalf      = in_offset;
    offHalf[0]   = 1'b0;
    offWord      = in_offset;
    offWord[1:0] = 2'b00;
    bitByte      = {in_offset, 3'b000};
    bitHalf      = {offHalf, 3'b000};
    bitWord      = {offWord, 3'b000};
    fieldByte    = in_data[bitByte +: 8];
    fieldHalf    = in_data[bitHalf +: 16];
    fieldWord    = in_data[bitWord +: 32];
    fmtData      = in_data;
    case (in_size)
      2'b00:   fmtData = in_signed ? DATA_WIDTH'($signed(fieldByte)) : DATA_WIDTH'(fieldByte);
      2'b01:   fmtData = in_signed ? DATA_WIDTH'($signed(fieldHalf)) : DATA_WIDTH'(fieldHalf);
      2'b10:   fmtData = in_signed ? DATA_WIDTH'($signed(fieldWord)) : DATA_WIDTH'(fieldWord);
      default: fmtData = in_data;
    endcase
  end

  // The head register tracks what the head will be after this edge, so out_data is a
  // plain flop that is zero whenever the buffer is empty.
  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    headD  = headQ;
    if (flush) begin
      wrPtrD = '0;
      rdPtrD = '0;
      countD = '0;
      headD  = '0;
    end else begin
      if (doPush) wrPtrD = wrPtrQ + PTR_W'(1);
      if (doPop)  rdPtrD = rdPtrQ + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   countD = countQ + CNT_W'(1);
        2'b01:   countD = countQ - CNT_W'(1);
        default: countD = countQ;
      endcase
      if (doPop) begin
        if (countQ == CNT_W'(1)) headD = doPush ? fmtData : '0;
        else                     headD = memQ[rdPtrQ + PTR_W'(1)];
      end else if (doPush && countQ == '0) begin
        headD = fmtData;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
      headQ  <= '0;
    end else begin
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
      headQ  <= headD;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) memQ[wrPtrQ] <= fmtData;
  end

endmodule

// File: tb/tb_memory_data_buffer.sv
// Directed self-checking bench for memory_data_buffer (DATA_WIDTH=32, DEPTH=4).
module tb_memory_data_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        in_signed;
  logic [1:0]  in_offset;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  count;

  int checkCount = 0;
  int failCount  = 0;

  memory_data_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_size(in_size), .in_signed(in_signed), .in_offset(in_offset),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus; inputs return to idle 1ns after the edge, where outputs are sampled.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [1:0] sz,
                               input logic sg, input logic [1:0] off, input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_size   = sz;
    in_signed = sg;
    in_offset = off;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_size = '0; in_signed = 1'b0; in_offset = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    reset = 1'b0;

    // Formatting cases, each pushed while popping the previous entry
    applyStimulus(1, 32'h12AB5680, 2'b00, 1, 2'd2, 0, 0);
    checkOutput("byte_s_count", count, 1);
    checkOutput("byte_s_valid", out_valid, 1);
    checkOutput("byte_s_data", out_data, 32'hFFFFFFAB);
    applyStimulus(1, 32'h12AB5680, 2'b00, 0, 2'd2, 1, 0);
    checkOutput("byte_u_count", count, 1);
    checkOutput("byte_u_data", out_data, 32'h000000AB);
    applyStimulus(1, 32'h80017FFF, 2'b01, 1, 2'd3, 1, 0);
    checkOutput("half_off3_data", out_data, 32'hFFFF8001);
    applyStimulus(1, 32'h80017FFF, 2'b01, 1, 2'd0, 1, 0);
    checkOutput("half_off0_data", out_data, 32'h00007FFF);
    applyStimulus(1, 32'h80000000, 2'b10, 1, 2'd1, 1, 0);
    checkOutput("word_data", out_data, 32'h80000000);
    applyStimulus(1, 32'hCAFEF00D, 2'b11, 1, 2'd3, 1, 0);
    checkOutput("full_size_data", out_data, 32'hCAFEF00D);
    applyStimulus(1, 32'h000000F0, 2'b00, 0, 2'd0, 1, 0);
    checkOutput("byte_off0_data", out_data, 32'h000000F0);
    applyStimulus(0, 32'h0, 2'b00, 0, 2'd0, 1, 0);
    checkOutput("drain_count", count, 0);
    checkOutput("drain_valid", out_valid, 0);
    checkOutput("drain_data", out_data, 0);
    applyStimulus(0, 32'h0, 2'b00, 0, 2'd0, 1, 0);
    checkOutput("empty_pop_count", count, 0);

    // Fill to capacity, then try a fifth push
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 32'h11111111 * i, 2'b11, 0, 2'd0, 0, 0);
      checkOutput("fill_count", count, i);
    end
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_head", out_data, 32'h11111111);
    applyStimulus(1, 32'h55555555, 2'b11, 0, 2'd0, 0, 0);
    checkOutput("full_drop_count", count, 4);
    applyStimulus(1, 32'h66666666, 2'b11, 0, 2'd0, 1, 0);
    checkOutput("full_pop_count", count, 3);
    checkOutput("full_pop_head", out_data, 32'h22222222);
    for (int i = 3; i <= 4; i++) begin
      applyStimulus(0, 32'h0, 2'b00, 0, 2'd0, 1, 0);
      checkOutput("full_drain_order", out_data, 32'h11111111 * i);
    end
    applyStimulus(0, 32'h0, 2'b00, 0, 2'd0, 1, 0);
    checkOutput("full_drain_empty", out_valid, 0);
    checkOutput("full_drain_data", out_data, 0);

    // Streaming at count=2 with pointers wrapping
    applyStimulus(1, 32'h00001000, 2'b11, 0, 2'd0, 0, 0);
    applyStimulus(1, 32'h00001001, 2'b11, 0, 2'd0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stream_head", out_data, 32'h00001000 + i);
      applyStimulus(1, 32'h00001002 + i, 2'b11, 0, 2'd0, 1, 0);
      checkOutput("stream_count", count, 2);
    end
    checkOutput("stream_tail0", out_data, 32'h0000100A);
    applyStimulus(0, 32'h0, 2'b00, 0, 2'd0, 1, 0);
    checkOutput("stream_tail1", out_data, 32'h0000100B);
    applyStimulus(0, 32'h0, 2'b00, 0, 2'd0, 1, 0);
    checkOutput("stream_empty", count, 0);

    // Flush beats a same-cycle push
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'hA0 + i, 2'b11, 0, 2'd0, 0, 0);
    checkOutput("preflush_count", count, 3);
    applyStimulus(1, 32'h0000DEAD, 2'b11, 0, 2'd0, 0, 1);
    checkOutput("flush_count", count, 0);
    checkOutput("flush_valid", out_valid, 0);
    checkOutput("flush_data", out_data, 0);
    applyStimulus(1, 32'h00000077, 2'b11, 0, 2'd0, 0, 0);
    checkOutput("postflush_head", out_data, 32'h00000077);
    checkOutput("postflush_count", count, 1);
    applyStimulus(0, 32'h0, 2'b00, 0, 2'd0, 1, 0);

    // Asynchronous reset pulse between edges
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'hB0 + i, 2'b11, 0, 2'd0, 0, 0);
    checkOutput("prereset_count", count, 3);
    #2 reset = 1'b1;
    #1;
    checkOutput("areset_count", count, 0);
    checkOutput("areset_valid", out_valid, 0);
    checkOutput("areset_in_ready", in_ready, 1);
    checkOutput("areset_data", out_data, 0);
    #1 reset = 1'b0;
    applyStimulus(1, 32'h00000099, 2'b11, 0, 2'd0, 0, 0);
    checkOutput("postreset_head", out_data, 32'h00000099);
    checkOutput("postreset_count", count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
